alu_sequencer: RTL

- Issue/writeback stage sitting directly upstream of the 8-bit ALU; owns an 8-entry x 8-bit register file.
- Accepts 16-bit instructions over a valid/ready handshake and reads operands.
- Drives the ALU's a/b/operation/do_operation inputs, captures the ALU's registered result one cycle later and writes it back to the destination register.
- Fully sequential: one instruction in flight, 3 cycles per ALU instruction, 2 per immediate load.

---
 rtl/alu_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Issue/writeback sequencer in front of the 8-bit ALU, with an 8 x 8-bit register file.
// Optional divide-by-zero trap enabled by defining ALU_SEQ_DIV0_TRAP_EN.
module alu_sequencer #(
  parameter int         REG_COUNT    = 8,
  parameter logic [3:0] LOADI_OPCODE = 4'b1111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_operation,
  output logic        alu_do_operation,
  input  logic [7:0]  alu_result,
  output logic        wb_valid,
  output logic [2:0]  wb_addr,
  output logic [7:0]  wb_data,
  input  logic [2:0]  dbg_addr,
  output logic [7:0]  dbg_data,
  output logic        err_div0
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WB = 2'd2} state_t;

  state_t      state;
  logic [7:0]  rf [REG_COUNT];
  logic [2:0]  rd;
  logic [7:0]  imm;
  logic        load_imm;
  logic [7:0]  wb_value;

  logic [3:0]  opcode;
  logic [2:0]  rd_sel;
  logic [2:0]  ra_sel;
  logic [2:0]  rb_sel;

  assign opcode = instr[15:12];
  assign rd_sel = instr[11:9];
  assign ra_sel = instr[8:6];
  assign rb_sel = instr[5:3];

  assign instr_ready = (state == IDLE) && rst_n;
  assign dbg_data    = rf[dbg_addr];

`ifdef ALU_SEQ_DIV0_TRAP_EN
  localparam logic [3:0] DIV_OPCODE = 4'b0011;
  logic div_trap;
  logic trap_now;
  logic err_flag;

  // A divide whose divisor register is zero is trapped at accept time.
  always_comb begin
    trap_now = 1'b0;
    if ((opcode == DIV_OPCODE) && (rf[rb_sel] == 8'h00)) begin
      trap_now = 1'b1;
    end else begin
      trap_now = 1'b0;
    end
  end

  assign err_div0 = err_flag;
`else
  assign err_div0 = 1'b0;
`endif

  // Writeback value: immediate, trap pattern, or the ALU's registered result.
  always_comb begin
    wb_value = alu_result;
    if (load_imm) begin
      wb_value = imm;
`ifdef ALU_SEQ_DIV0_TRAP_EN
    end else if (div_trap) begin
      wb_value = 8'hFF;
`endif
    end else begin
      wb_value = alu_result;
    end
  end

  // Writeback port is only active in the WB state.
  always_comb begin
    if (state == WB) begin
      wb_valid = 1'b1;
      wb_addr  = rd;
      wb_data  = wb_value;
    end else begin
      wb_valid = 1'b0;
      wb_addr  = 3'd0;
      wb_data  = 8'h00;
    end
  end

  // Sequencer FSM, register file and registered ALU drive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      rd               <= 3'd0;
      imm              <= 8'h00;
      load_imm         <= 1'b0;
      alu_a            <= 8'h00;
      alu_b            <= 8'h00;
      alu_operation    <= 4'h0;
      alu_do_operation <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) begin
        rf[i] <= 8'h00;
      end
`ifdef ALU_SEQ_DIV0_TRAP_EN
      div_trap         <= 1'b0;
      err_flag         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            rd  <= rd_sel;
            imm <= instr[7:0];
            if (opcode == LOADI_OPCODE) begin
              load_imm <= 1'b1;
`ifdef ALU_SEQ_DIV0_TRAP_EN
              div_trap <= 1'b0;
`endif
              state    <= WB;
            end else begin
              load_imm      <= 1'b0;
              alu_a         <= rf[ra_sel];
              alu_b         <= rf[rb_sel];
              alu_operation <= opcode;
`ifdef ALU_SEQ_DIV0_TRAP_EN
              div_trap         <= trap_now;
              alu_do_operation <= !trap_now;
`else
              alu_do_operation <= 1'b1;
`endif
              state         <= ISSUE;
            end
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          alu_do_operation <= 1'b0;
          state            <= WB;
        end
        WB: begin
          rf[rd] <= wb_value;
`ifdef ALU_SEQ_DIV0_TRAP_EN
          if (div_trap) begin
            err_flag <= 1'b1;
          end else begin
            err_flag <= err_flag;
          end
`endif
          state <= IDLE;
        end
        default: begin
          alu_do_operation <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end

endmodule
